// File: rtl/ask_bit_serializer.sv
// ask_bit_serializer: frames parallel words (preamble, start, data LSB first, optional even parity, stop)
// into a registered ASK symbol stream with a one-word holding register for gapless back-to-back frames.
module ask_bit_serializer #(
  parameter int CLKS_PER_BIT  = 100,
  parameter int DATA_BITS     = 8,
  parameter int PREAMBLE_BITS = 8,
  parameter int PARITY_EN     = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 data_out,
  output logic                 busy,
  output logic                 bit_strobe,
  output logic                 frame_done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = 6;
  typedef enum logic [2:0] {IDLE, PREAMBLE, START, DATA, PARITY, STOP} state_t;
  localparam state_t FIRST = (PREAMBLE_BITS == 0) ? START : PREAMBLE;
  state_t state, nstate;
  logic [CW-1:0] cnt, ncnt;
  logic [IW-1:0] idx, nidx;
  logic [DATA_BITS-1:0] word, nword, hold, sh;
  logic hold_full, load, wrap, sym, accept;
  assign wrap = cnt == CW'(CLKS_PER_BIT - 1);
  assign accept = tx_valid && !hold_full;
  assign tx_ready = !hold_full;
  always_comb begin
    nstate = state;
    ncnt = cnt;
    nidx = idx;
    nword = word;
    load = 1'b0;
    if (state == IDLE) load = hold_full;
    else if (!wrap) ncnt = cnt + 1'b1;
    else begin
      ncnt = '0;
      nidx = idx + 1'b1;
      case (state)
        PREAMBLE: if (idx == IW'(PREAMBLE_BITS - 1)) nstate = START;
        START:    nstate = DATA;
        DATA:     if (idx == IW'(DATA_BITS - 1)) nstate = (PARITY_EN != 0) ? PARITY : STOP;
        PARITY:   nstate = STOP;
        default:  if (hold_full) load = 1'b1; else nstate = IDLE;
      endcase
    end
    if (load) begin
      nstate = FIRST;
      nword = hold;
      ncnt = '0;
    end
    // every state entry, including STOP straight into the next frame, restarts the bit index
    if (nstate != state) nidx = '0;
    sh = nword >> nidx;
    sym = (nstate == PREAMBLE) ? ~nidx[0] :
          (nstate == START)    ? 1'b1 :
          (nstate == DATA)     ? sh[0] :
          (nstate == PARITY)   ? ^nword : 1'b0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      word <= '0;
      hold <= '0;
      hold_full <= 1'b0;
      data_out <= 1'b0;
      busy <= 1'b0;
      bit_strobe <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= nstate;
      cnt <= ncnt;
      idx <= nidx;
      word <= nword;
      hold_full <= (hold_full && !load) || accept;
      if (accept) hold <= tx_data;
      data_out <= sym;
      busy <= nstate != IDLE;
      bit_strobe <= (nstate != IDLE) && (ncnt == '0);
      frame_done <= (nstate == STOP) && (ncnt == CW'(CLKS_PER_BIT - 1));
    end
endmodule
